blockmem_dp: RTL and testbench

Parametrised dual-port synchronous block memory for the modexp datapath. Port A serves the host API; port B serves the internal operand/result engine. Both ports are independent read/write ports with a registered read-valid indication. A built-in clear engine zeroes the whole array after reset or on command, so no operand data survives between operations.

---
 rtl/blockmem_dp.sv | 124 ++++++++++++
 tb/tb_blockmem_dp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blockmem_dp.sv
// Dual-port block memory with a clear engine that zeroes the array after reset or init; read latency 1
// (2 with BLOCKMEM_DP_OUTREG_EN); no backpressure except ready_o low for DEPTH cycles while clearing.
module blockmem_dp #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  init_i,
    output logic                  ready_o,
    input  logic                  a_rd_i,
    input  logic                  a_wr_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_write_data_i,
    output logic [DATA_WIDTH-1:0] a_read_data_o,
    output logic                  a_read_valid_o,
    input  logic                  b_rd_i,
    input  logic                  b_wr_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_write_data_i,
    output logic [DATA_WIDTH-1:0] b_read_data_o,
    output logic                  b_read_valid_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   a_rdat_q, b_rdat_q;
    logic                    a_rvld_q, b_rvld_q;
    logic                    idle, a_rd_en, b_rd_en, a_wr_en, b_wr_en;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (init_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end
    end

    assign idle    = (state_q == ST_IDLE);
    assign ready_o = idle;
    assign a_rd_en = idle & a_rd_i;
    assign b_rd_en = idle & b_rd_i;
    // Port B wins a same-address write collision.
    assign a_wr_en = idle & a_wr_i & ~(b_wr_i & (b_addr_i == a_addr_i));
    assign b_wr_en = idle & b_wr_i;

    always_ff @(posedge clk_i) begin
        if (!idle) mem[cnt_q] <= '0;
        if (a_wr_en) mem[a_addr_i] <= a_write_data_i;
        if (b_wr_en) mem[b_addr_i] <= b_write_data_i;
    end

    // Non-blocking reads of mem return the word from before this edge's writes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_rdat_q <= '0;
            a_rvld_q <= 1'b0;
            b_rdat_q <= '0;
            b_rvld_q <= 1'b0;
        end else begin
            a_rvld_q <= a_rd_en;
            b_rvld_q <= b_rd_en;
            if (a_rd_en) a_rdat_q <= mem[a_addr_i];
            if (b_rd_en) b_rdat_q <= mem[b_addr_i];
        end
    end

`ifdef BLOCKMEM_DP_OUTREG_EN
    logic [DATA_WIDTH-1:0] a_rdat2_q, b_rdat2_q;
    logic                  a_rvld2_q, b_rvld2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_rdat2_q <= '0;
            a_rvld2_q <= 1'b0;
            b_rdat2_q <= '0;
            b_rvld2_q <= 1'b0;
        end else begin
            a_rvld2_q <= a_rvld_q & ~init_i;
            b_rvld2_q <= b_rvld_q & ~init_i;
            if (a_rvld_q) a_rdat2_q <= a_rdat_q;
            if (b_rvld_q) b_rdat2_q <= b_rdat_q;
        end
    end

    assign a_read_data_o  = a_rdat2_q;
    assign a_read_valid_o = a_rvld2_q;
    assign b_read_data_o  = b_rdat2_q;
    assign b_read_valid_o = b_rvld2_q;
`else
    assign a_read_data_o  = a_rdat_q;
    assign a_read_valid_o = a_rvld_q;
    assign b_read_data_o  = b_rdat_q;
    assign b_read_valid_o = b_rvld_q;
`endif

endmodule

// File: tb/tb_blockmem_dp.sv
// Bench for blockmem_dp: array-level reference model checked every cycle, plus directed literal checks.
module tb_blockmem_dp;
`ifdef BLOCKMEM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1, init = 1'b0, ready;
    logic        a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wd = '0, b_wd = '0, a_rdat, b_rdat;
    logic        a_rvld, b_rvld;

    int checks = 0;
    int failures = 0;

    blockmem_dp #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset), .init_i(init), .ready_o(ready),
        .a_rd_i(a_rd), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_write_data_i(a_wd),
        .a_read_data_o(a_rdat), .a_read_valid_o(a_rvld),
        .b_rd_i(b_rd), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_write_data_i(b_wd),
        .b_read_data_o(b_rdat), .b_read_valid_o(b_rvld)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: clearing is one bulk zero, then a countdown of busy cycles.
    logic [31:0] m_mem [DEPTH];
    int          clr_left = DEPTH;
    bit          model_ok = 1'b0;
    logic [31:0] s1_ad = '0, s1_bd = '0, s2_ad = '0, s2_bd = '0;
    bit          s1_av = 1'b0, s1_bv = 1'b0, s2_av = 1'b0, s2_bv = 1'b0;

    always @(posedge clk) begin
        logic [31:0] ra, rb;
        bit is_idle, nva, nvb;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            clr_left = DEPTH;
            s1_ad = '0; s1_bd = '0; s2_ad = '0; s2_bd = '0;
            s1_av = 0; s1_bv = 0; s2_av = 0; s2_bv = 0;
            model_ok = 1'b1;
        end else begin
            is_idle = (clr_left == 0);
            nva = is_idle && a_rd;
            nvb = is_idle && b_rd;
            ra = m_mem[a_addr];
            rb = m_mem[b_addr];
            if (is_idle) begin
                if (a_wr && !(b_wr && b_addr == a_addr)) m_mem[a_addr] = a_wd;
                if (b_wr) m_mem[b_addr] = b_wd;
            end
            if (s1_av) s2_ad = s1_ad;
            if (s1_bv) s2_bd = s1_bd;
            s2_av = s1_av && !init;
            s2_bv = s1_bv && !init;
            if (nva) s1_ad = ra;
            if (nvb) s1_bd = rb;
            s1_av = nva;
            s1_bv = nvb;
            if (init) begin
                clr_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else if (!is_idle) begin
                clr_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("ready", {31'b0, ready}, {31'b0, clr_left == 0});
            check("a_valid", {31'b0, a_rvld}, {31'b0, (LAT == 2) ? s2_av : s1_av});
            check("b_valid", {31'b0, b_rvld}, {31'b0, (LAT == 2) ? s2_bv : s1_bv});
            check("a_data", a_rdat, (LAT == 2) ? s2_ad : s1_ad);
            check("b_data", b_rdat, (LAT == 2) ? s2_bd : s1_bd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0; init = 0;
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (!ready && n < bound) begin
            n++;
            tick();
        end
    endtask

    task automatic rd_chk(input bit pb, input logic [7:0] ad, input logic [31:0] ex, input string nm);
        if (pb) begin b_rd = 1; b_addr = ad; end
        else begin a_rd = 1; a_addr = ad; end
        tick();
        a_rd = 0; b_rd = 0;
        repeat (LAT - 1) begin
            check({nm, "_early_valid"}, {31'b0, pb ? b_rvld : a_rvld}, 32'd0);
            tick();
        end
        check({nm, "_valid"}, {31'b0, pb ? b_rvld : a_rvld}, 32'd1);
        check({nm, "_data"}, pb ? b_rdat : a_rdat, ex);
        tick();
        check({nm, "_valid_pulse"}, {31'b0, pb ? b_rvld : a_rvld}, 32'd0);
    endtask

    initial begin
        int n, vseen;
        reset = 1;
        idle_in();
        tick();
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_a_data", a_rdat, 32'd0);
        reset = 0;
        wait_ready(1000, n);
        check("rst_clear_cycles", n, 32'd256);

        rd_chk(0, 8'h00, 32'h0, "rd_a_00");
        rd_chk(0, 8'h7f, 32'h0, "rd_a_7f");
        rd_chk(0, 8'hff, 32'h0, "rd_a_ff");

        a_wr = 1; a_addr = 8'h10; a_wd = 32'hdeadbeef;
        tick();
        idle_in();
        rd_chk(1, 8'h10, 32'hdeadbeef, "wr_a_rd_b");

        a_wr = 1; a_addr = 8'h20; a_wd = 32'h11111111;
        b_wr = 1; b_addr = 8'h20; b_wd = 32'h22222222;
        tick();
        idle_in();
        rd_chk(0, 8'h20, 32'h22222222, "collide_a");
        rd_chk(1, 8'h20, 32'h22222222, "collide_b");

        b_wr = 1; b_addr = 8'h30; b_wd = 32'h00000001;
        tick();
        idle_in();
        a_wr = 1; a_addr = 8'h30; a_wd = 32'hcafebabe;
        b_rd = 1; b_addr = 8'h30;
        tick();
        idle_in();
        repeat (LAT - 1) tick();
        check("rd_old_valid", {31'b0, b_rvld}, 32'd1);
        check("rd_old_data", b_rdat, 32'h00000001);
        tick();
        rd_chk(1, 8'h30, 32'hcafebabe, "rd_new");

        for (int i = 0; i < 3000; i++) begin
            a_rd = $urandom_range(0, 1); a_wr = $urandom_range(0, 1);
            b_rd = $urandom_range(0, 1); b_wr = $urandom_range(0, 1);
            a_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3));
            b_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3));
            a_wd = $urandom; b_wd = $urandom;
            init = ($urandom_range(0, 399) == 0);
            tick();
        end
        idle_in();
        wait_ready(1000, n);
        check("rand_ready_timeout", {31'b0, ready}, 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            a_wr = 1; a_addr = 8'(i); a_wd = 32'(i) + 32'h100;
            tick();
        end
        idle_in();
        rd_chk(0, 8'h55, 32'h155, "fill_55");
        init = 1;
        tick();
        init = 0;
        a_wr = 1; a_addr = 8'h55; a_wd = 32'h12345678;
        a_rd = 1; b_rd = 1; b_addr = 8'h55;
        n = 0; vseen = 0;
        while (!ready && n < 1000) begin
            if (a_rvld || b_rvld) vseen++;
            n++;
            tick();
        end
        idle_in();
        check("init_clear_cycles", n, 32'd256);
        check("init_no_valid", vseen, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            a_rd = 1; a_addr = 8'(i);
            b_rd = 1; b_addr = 8'(255 - i);
            tick();
        end
        idle_in();
        repeat (2) tick();
        rd_chk(0, 8'h55, 32'h0, "clr_55");

        init = 1;
        tick();
        init = 0;
        repeat (100) tick();
        reset = 1;
        tick();
        check("midclr_rst_ready", {31'b0, ready}, 32'd0);
        check("midclr_rst_valid", {31'b0, a_rvld}, 32'd0);
        reset = 0;
        wait_ready(1000, n);
        check("midclr_rst_cycles", n, 32'd256);
        rd_chk(1, 8'hff, 32'h0, "final_b_ff");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
